// File: rtl/sys_pkg.sv
// Shared types and constants for the 2x2 systolic array driver.
package sys_pkg;

  localparam int SYS_DW      = 16;
  localparam int LOAD_CYCLES = 4;

  // Word positions inside the packed {w11,w10,w01,w00} weight bus.
  localparam int W00_IDX = 0;
  localparam int W01_IDX = 1;
  localparam int W10_IDX = 2;
  localparam int W11_IDX = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_2x2_ctrl_if.sv
// Host-side handshakes plus the raw array connections for systolic_2x2_ctrl.
interface systolic_2x2_ctrl_if #(
  parameter int DW = 16
);
  logic            w_valid;
  logic            w_ready;
  logic [4*DW-1:0] w_data;
  logic            x_valid;
  logic            x_ready;
  logic [DW-1:0]   x_data;
  logic            r_valid;
  logic            r_ready;
  logic [4*DW-1:0] r_data;
  logic            arr_load_en;
  logic [DW-1:0]   arr_weight;
  logic [DW-1:0]   arr_data;
  logic [2*DW-1:0] arr_row0;
  logic [2*DW-1:0] arr_row1;
  logic            busy;

  modport master (
    output w_valid, w_data, x_valid, x_data, r_ready, arr_row0, arr_row1,
    input  w_ready, x_ready, r_valid, r_data, arr_load_en, arr_weight, arr_data, busy
  );

  modport slave (
    input  w_valid, w_data, x_valid, x_data, r_ready, arr_row0, arr_row1,
    output w_ready, x_ready, r_valid, r_data, arr_load_en, arr_weight, arr_data, busy
  );
endinterface

// File: rtl/sys_result_fifo.sv
// Small synchronous FIFO holding captured array row pairs until the host takes them.
module sys_result_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !pop_i && count_q == CW'(DEPTH)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(pop_i && count_q == '0));

endmodule

// File: rtl/systolic_2x2_ctrl.sv
// Driver for the 2x2 systolic array: weight serialisation, sample pacing with
// result credits, and fixed-latency capture of row results into a FIFO.
//
//   state | meaning
//   IDLE  | no valid weights in the array, waiting for a matrix
//   LOAD  | shifting the 4 weights into the array, w11 first
//   READY | weights valid, streaming samples
module systolic_2x2_ctrl
  import sys_pkg::*;
#(
  parameter int DW         = SYS_DW,
  parameter int ARRAY_LAT  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  systolic_2x2_ctrl_if.slave bus
);
  localparam int AW  = 2 * DW;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int LCW = $clog2(LOAD_CYCLES);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_e               state_q, state_d;
  logic [4*DW-1:0]      w_q, w_d;
  logic [LCW-1:0]       load_cnt_q, load_cnt_d;
  logic [DW-1:0]        arr_data_q, arr_data_d;
  logic                 data_vld_q, data_vld_d;
  logic [ARRAY_LAT-1:0] tag_q, tag_d;
  logic [CW-1:0]        inflight_q, inflight_d;

  logic          w_rdy, x_rdy, load_en, w_fire, x_fire;
  logic          credit_ok, push, pop, fifo_valid;
  logic [CW-1:0] fifo_count;
  logic [2*AW-1:0] fifo_rdata;

  // Registered counts only: a pop in this cycle frees its slot next cycle.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_C;
  assign push      = tag_q[ARRAY_LAT-1];
  assign pop       = fifo_valid && bus.r_ready && !rst_i;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    load_cnt_d = load_cnt_q;
    w_rdy      = 1'b0;
    x_rdy      = 1'b0;
    load_en    = 1'b0;

    case (state_q)
      IDLE: w_rdy = 1'b1;
      LOAD: begin
        load_en = 1'b1;
        if (load_cnt_q == '0) state_d = READY;
        else                  load_cnt_d = load_cnt_q - LCW'(1);
      end
      READY: begin
        // Reload wins over streaming; wait until nothing is still inside the array.
        if (bus.w_valid) w_rdy = (inflight_q == '0);
        else             x_rdy = credit_ok;
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      w_rdy   = 1'b0;
      x_rdy   = 1'b0;
      load_en = 1'b0;
    end

    w_fire = w_rdy && bus.w_valid;
    x_fire = x_rdy && bus.x_valid;

    if (w_fire) begin
      state_d    = LOAD;
      w_d        = bus.w_data;
      load_cnt_d = LCW'(W11_IDX);
    end

    arr_data_d = x_fire ? bus.x_data : '0;
    data_vld_d = x_fire;
    tag_d      = tag_q << 1;
    tag_d[0]   = data_vld_q;
    inflight_d = inflight_q + CW'(x_fire) - CW'(push);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      w_q        <= '0;
      load_cnt_q <= '0;
      arr_data_q <= '0;
      data_vld_q <= 1'b0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      load_cnt_q <= load_cnt_d;
      arr_data_q <= arr_data_d;
      data_vld_q <= data_vld_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  sys_result_fifo #(
    .W    (2*AW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_data_i({bus.arr_row1, bus.arr_row0}),
    .pop_i      (pop),
    .valid_o    (fifo_valid),
    .rdata_o    (fifo_rdata),
    .count_o    (fifo_count)
  );

  assign bus.w_ready     = w_rdy;
  assign bus.x_ready     = x_rdy;
  assign bus.arr_load_en = load_en;
  assign bus.arr_weight  = load_en ? w_q[int'(load_cnt_q)*DW +: DW] : '0;
  assign bus.arr_data    = rst_i ? '0 : arr_data_q;
  assign bus.r_valid     = fifo_valid && !rst_i;
  assign bus.r_data      = (fifo_valid && !rst_i) ? fifo_rdata : '0;
  assign bus.busy        = !rst_i && ((state_q != READY) || (inflight_q != '0));

endmodule
